// File: rtl/demux_1x16_deserializer_if.sv
// Serial-in / parallel-out bundle for demux_1x16_deserializer.
// master drives the serial side, slave is the deserializer.
interface demux_1x16_deserializer_if #(
    parameter int WIDTH = 16
);
    logic             din;
    logic             din_valid;
    logic             frame_start;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             busy;
    logic             frame_err;

    modport master (
        output din, din_valid, frame_start,
        input  dout, dout_valid, busy, frame_err
    );

    modport slave (
        input  din, din_valid, frame_start,
        output dout, dout_valid, busy, frame_err
    );
endinterface

// File: rtl/demux_1x16_deserializer.sv
// 1-bit serial to WIDTH-bit parallel deserializer; bit k of a frame lands on dout[k]. Optional even parity: DEMUX_PARITY_EN.
// Latency: dout/dout_valid register on the edge accepting the last bit (parity bit when enabled).
// No backpressure: every din_valid cycle is consumed; gaps of any length are allowed.
module demux_1x16_deserializer #(
    parameter int WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    demux_1x16_deserializer_if.slave    bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_PARITY  = 2'd2
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_valid;
    logic             r_frame_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_shadow     <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_dout_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            if (bus.din_valid) begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.frame_start) begin
                            r_shadow[0] <= bus.din;
                            r_cnt       <= CW'(1);
                            r_state     <= S_COLLECT;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end
                    S_COLLECT: begin
                        if (bus.frame_start) begin
                            // restart: the new bit is channel 0 of a fresh frame
                            r_frame_err <= 1'b1;
                            r_shadow[0] <= bus.din;
                            r_cnt       <= CW'(1);
                        end else if (r_cnt == LAST) begin
`ifdef DEMUX_PARITY_EN
                            r_shadow[WIDTH-1] <= bus.din;
                            r_cnt             <= '0;
                            r_state           <= S_PARITY;
`else
                            r_dout       <= {bus.din, r_shadow[WIDTH-2:0]};
                            r_dout_valid <= 1'b1;
                            r_cnt        <= '0;
                            r_state      <= S_IDLE;
`endif
                        end else begin
                            r_shadow[r_cnt] <= bus.din;
                            r_cnt           <= r_cnt + CW'(1);
                        end
                    end
`ifdef DEMUX_PARITY_EN
                    S_PARITY: begin
                        if (bus.frame_start) begin
                            r_frame_err <= 1'b1;
                            r_shadow[0] <= bus.din;
                            r_cnt       <= CW'(1);
                            r_state     <= S_COLLECT;
                        end else begin
                            // all WIDTH shadow bits are fresh here, so the full reduction is valid
                            if ((^r_shadow ^ bus.din) == 1'b0) begin
                                r_dout       <= r_shadow;
                                r_dout_valid <= 1'b1;
                            end else begin
                                r_frame_err  <= 1'b1;
                            end
                            r_state <= S_IDLE;
                        end
                    end
`endif
                    default: begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.frame_err  = r_frame_err;
    assign bus.busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_demux_1x16_deserializer.sv
// Scoreboard bench for demux_1x16_deserializer: frame-level reference model feeds an event queue,
// a negedge monitor pops and compares whenever the DUT pulses dout_valid or frame_err.
module tb_demux_1x16_deserializer;
    localparam int W = 16;
`ifdef DEMUX_PARITY_EN
    localparam int FLEN = W + 1;
`else
    localparam int FLEN = W;
`endif

    typedef struct packed {
        logic         is_err;
        logic [W-1:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    demux_1x16_deserializer_if #(.WIDTH(W)) bus ();

    demux_1x16_deserializer #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // reference model state: bits of the frame in progress, last good word, pending events
    bit       cur[$];
    ev_t      evq[$];
    logic [W-1:0] m_dout = '0;
    logic     m_busy = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ev_t mk_ev(input logic is_err, input logic [W-1:0] d);
        ev_t e;
        e.is_err = is_err;
        e.data   = d;
        return e;
    endfunction

    task automatic model_accept(input logic fs, input logic d);
        logic [W-1:0] w;
        logic         par;
        if (fs) begin
            if (cur.size() != 0) evq.push_back(mk_ev(1'b1, '0));
            cur.delete();
            cur.push_back(d);
        end else if (cur.size() == 0) begin
            evq.push_back(mk_ev(1'b1, '0));
        end else begin
            cur.push_back(d);
            if (cur.size() == FLEN) begin
                w = '0;
                par = 1'b0;
                for (int k = 0; k < W; k++) w[k] = cur[k];
                for (int k = 0; k < FLEN; k++) par ^= cur[k];
`ifndef DEMUX_PARITY_EN
                par = 1'b0;
`endif
                if (par == 1'b0) begin
                    evq.push_back(mk_ev(1'b0, w));
                    m_dout = w;
                end else begin
                    evq.push_back(mk_ev(1'b1, '0));
                end
                cur.delete();
            end
        end
        m_busy = (cur.size() != 0);
    endtask

    task automatic send_bit(input logic fs, input logic d);
        bus.din_valid   = 1'b1;
        bus.frame_start = fs;
        bus.din         = d;
        @(posedge clk);
        #1;
        model_accept(fs, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.din_valid   = 1'b0;
            bus.frame_start = 1'($urandom_range(0, 1));
            bus.din         = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
    endtask

    // nbits data bits of word (channel 0 first), optional gap after each bit, parity bit when enabled
    task automatic send_frame(input logic [W-1:0] word, input int gap, input logic parbit);
        for (int k = 0; k < W; k++) begin
            send_bit(k == 0, word[k]);
            if (gap > 0) idle(gap);
        end
`ifdef DEMUX_PARITY_EN
        send_bit(1'b0, parbit);
        if (gap > 0) idle(gap);
`else
        if (parbit) idle(0);
`endif
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (rst_n) begin
            check("busy", bus.busy, m_busy);
            check("dout_hold", bus.dout, m_dout);
            if (bus.dout_valid || bus.frame_err) begin
                if (evq.size() == 0) begin
                    check("unexpected_event", {bus.dout_valid, bus.frame_err}, 2'b00);
                end else begin
                    e = evq.pop_front();
                    check("event_kind", {bus.dout_valid, bus.frame_err}, e.is_err ? 2'b01 : 2'b10);
                    if (!e.is_err) check("dout", bus.dout, e.data);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] w;
        bus.din = 1'b0;
        bus.din_valid = 1'b0;
        bus.frame_start = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", bus.dout, 0);
        check("rst_valid", bus.dout_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_err", bus.frame_err, 0);
        rst_n = 1'b1;

        // basic, gapped, back-to-back
        send_frame(16'hA5C3, 0, ^16'hA5C3);
        idle(3);
        send_frame(16'hA5C3, 2, ^16'hA5C3);
        idle(2);
        send_frame(16'h0001, 0, 1'b1);
        send_frame(16'h8000, 0, 1'b1);
        idle(2);

        // abort at bit 7, then full 0xFFFF
        for (int k = 0; k < 7; k++) send_bit(k == 0, 1'($urandom_range(0, 1)));
        send_frame(16'hFFFF, 0, 1'b0);
        idle(2);

        // stray bits in idle
        for (int k = 0; k < 3; k++) send_bit(1'b0, 1'b1);
        idle(2);

        // async reset mid-frame, between edges
        for (int k = 0; k < 5; k++) send_bit(k == 0, 1'b1);
        bus.din_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_dout", bus.dout, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_valid", bus.dout_valid, 0);
        check("arst_err", bus.frame_err, 0);
        cur.delete();
        evq.delete();
        m_dout = '0;
        m_busy = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_frame(16'h1234, 0, ^16'h1234);
        idle(2);

`ifdef DEMUX_PARITY_EN
        send_frame(16'h0003, 0, 1'b0);
        send_frame(16'h0007, 0, 1'b0);
        idle(2);
        check("parity_hold", bus.dout, 16'h0003);
        // frame_start on the parity slot restarts
        for (int k = 0; k < W; k++) send_bit(k == 0, 1'b1);
        send_frame(16'h00F0, 0, 1'b0);
        idle(2);
`endif

        // randomized traffic
        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(0, 3))
                0, 1: begin
                    w = W'($urandom);
                    send_frame(w, $urandom_range(0, 1), ($urandom_range(0, 3) == 0) ? ~(^w) : ^w);
                end
                2: begin
                    for (int k = 0; k < int'($urandom_range(1, FLEN - 1)); k++)
                        send_bit(k == 0, 1'($urandom_range(0, 1)));
                end
                default: begin
                    for (int k = 0; k < int'($urandom_range(1, 4)); k++)
                        send_bit(1'b0, 1'($urandom_range(0, 1)));
                end
            endcase
            idle($urandom_range(0, 2));
        end
        idle(4);
        check("events_drained", evq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/demux_1x16_deserializer.md
Name: demux_1x16_deserializer

Overview:
- Receive-side counterpart to the team's 16:1 select mux.
- Accepts a 1-bit serial stream: one bit per valid cycle, channel 0 first, with a frame-start marker.
- Distributes the bits into a WIDTH-bit parallel register, so bit k lands on dout[k] (the same index a mux select of k would pick from in[k]).
- Presents the completed word with a one-cycle valid pulse; sits between a serial/TDM link and parallel datapath logic.

Parameters:
- WIDTH, 16, number of output channels (bits per frame); legal range 2..64.
- CW, $clog2(WIDTH), channel counter width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  1  serial data bit.
- din_valid  input  1  din is accepted this cycle when high.
- frame_start  input  1  marks the accepted bit as channel 0; ignored when din_valid=0.
- dout  output  WIDTH  last completed frame; dout[k] = channel k bit.
- dout_valid  output  1  one-cycle pulse when dout updates.
- busy  output  1  high while a frame is partially collected.
- frame_err  output  1  one-cycle pulse on protocol error.

Behaviour:
- One clock, clk; reset rst_n is asynchronous, active-low. Assertion takes effect immediately, regardless of clk.
- Reset values: state=IDLE, cnt=0, shadow=0, dout=0, dout_valid=0, busy=0, frame_err=0.
- Reset mid-frame discards the partial frame. dout returns to 0.
- "Accepted bit" means din_valid=1 at a rising edge. Cycles with din_valid=0 are gaps: no state change, no timeout, unlimited length.
- IDLE state:
  - Accepted bit with frame_start=1: shadow[0]<=din, cnt<=1, go to COLLECT.
  - Accepted bit with frame_start=0: bit dropped, frame_err pulses next cycle, stay in IDLE.
- COLLECT state:
  - Accepted bit with frame_start=0 and cnt<WIDTH-1: shadow[cnt]<=din, cnt<=cnt+1.
  - Accepted bit with frame_start=0 and cnt==WIDTH-1: dout<={din, shadow[WIDTH-2:0]} placed so that din goes to dout[WIDTH-1]. dout_valid=1 for exactly one cycle after that edge. cnt<=0, go to IDLE.
  - Accepted bit with frame_start=1 (abort/restart): partial frame discarded and frame_err pulses. The new bit becomes channel 0 (shadow[0]<=din, cnt<=1); state stays COLLECT. dout is unchanged.
- Latency: dout/dout_valid are registered and appear on the edge that accepts the last bit. They are visible in the cycle following acceptance.
- Back-to-back frames need zero idle cycles: the first bit of frame N+1 may be accepted on the cycle right after the last bit of frame N.
- dout holds its value between frames. It changes only on completion or reset.
- busy = (state==COLLECT), driven from registered state.
- shadow bits not yet written in the current frame hold stale values. They are never exposed, because dout updates only on completion.
- cnt never exceeds WIDTH-1; no wrap-around occurs outside the completion transition.

Optional Feature:
- Macro: DEMUX_PARITY_EN.
- Defined:
  - After the WIDTH data bits the FSM enters a PARITY state instead of completing. The next accepted bit is an even-parity bit, so XOR of data bits ^ parity bit must be 0.
  - Parity good: dout updates and dout_valid pulses.
  - Parity bad: dout unchanged, frame_err pulses.
  - Either way the FSM returns to IDLE.
  - frame_start=1 on the parity cycle is treated as abort/restart, as in COLLECT.
  - busy is high in PARITY.
- Undefined: no PARITY state and no parity logic; completion occurs on the last data bit as described above.

Test Plan:
- Reset + basic frame: rst_n low for 3 cycles. Then 16 accepted bits of pattern 16'hA5C3, channel 0 with frame_start=1, no gaps. Required: dout=16'hA5C3 and dout_valid high for 1 cycle after the 16th bit; busy high for cycles 1–15.
- Gapped stream: same frame with din_valid=0 for 2 cycles between every bit. Required: dout=16'hA5C3, a single dout_valid pulse, no frame_err.
- Back-to-back frames: 16'h0001 immediately followed by 16'h8000. Required: two dout_valid pulses 16 cycles apart, with dout=16'h0001 then dout=16'h8000.
- Abort/restart: frame_start at bit 7 of a frame, then a full 16-bit 16'hFFFF. Required: one frame_err pulse; a single dout_valid with dout=16'hFFFF; no update at the abort.
- Stray data and async reset: 3 accepted bits in IDLE without frame_start gives 3 frame_err pulses and dout unchanged. Then rst_n asserted mid-frame, between clock edges: outputs go to 0 immediately, and the following frame 16'h1234 completes correctly.
- Parity (DEMUX_PARITY_EN): 16'h0003 with parity bit 0 gives dout=16'h0003 and dout_valid. 16'h0007 with parity bit 0 gives frame_err and dout remains 16'h0003.
